// File: rtl/axi_resp_router.sv
// axi_resp_router: steers AR/AW/W handshakes and R/B responses between the
// granted master and NUM_S slaves, with a built-in default slave that answers
// unmapped regions with DECERR.
`timescale 1ns/1ps
module axi_resp_router #(
    parameter int NUM_S      = 2,
    parameter int ID_W       = 8,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REGION_LSB = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET,

    input  logic                      ARVALID,
    input  logic [ADDR_W-1:0]         ARADDR,
    input  logic [ID_W-1:0]           ARID,
    input  logic [3:0]                ARLEN,
    output logic                      ARREADY,

    output logic [ID_W-1:0]           RID,
    output logic [DATA_W-1:0]         RDATA,
    output logic [1:0]                RRESP,
    output logic                      RLAST,
    output logic                      RVALID,
    input  logic                      RREADY,

    input  logic                      AWVALID,
    input  logic [ADDR_W-1:0]         AWADDR,
    input  logic [ID_W-1:0]           AWID,
    output logic                      AWREADY,

    input  logic                      WVALID,
    input  logic                      WLAST,
    output logic                      WREADY,

    output logic [ID_W-1:0]           BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,

    input  logic [NUM_S-1:0]          ARREADY_S,
    input  logic [NUM_S-1:0]          AWREADY_S,
    input  logic [NUM_S-1:0]          WREADY_S,

    input  logic [NUM_S*ID_W-1:0]     RID_S,
    input  logic [NUM_S*DATA_W-1:0]   RDATA_S,
    input  logic [NUM_S*2-1:0]        RRESP_S,
    input  logic [NUM_S-1:0]          RLAST_S,
    input  logic [NUM_S-1:0]          RVALID_S,

    input  logic [NUM_S*ID_W-1:0]     BID_S,
    input  logic [NUM_S*2-1:0]        BRESP_S,
    input  logic [NUM_S-1:0]          BVALID_S,

    output logic [NUM_S-1:0]          RREADY_S,
    output logic [NUM_S-1:0]          BREADY_S
);

    // Select encoding: 0..NUM_S-1 are real slaves, NUM_S is the default slave.
    localparam int SEL_W    = $clog2(NUM_S + 1);
    localparam int REGION_W = ADDR_W - REGION_LSB;
    localparam logic [SEL_W-1:0] SEL_DEF = SEL_W'(NUM_S);

    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_DATA = 2'd1;
    localparam logic [1:0] R_DERR = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_sel;
    logic [ID_W-1:0]  r_id;
    logic [3:0]       r_len;
    logic [3:0]       r_cnt;

    logic [1:0]       w_state;
    logic [SEL_W-1:0] w_sel;
    logic [ID_W-1:0]  w_id;

    logic [SEL_W-1:0] ar_sel;
    logic [SEL_W-1:0] aw_sel;

    // Offset bits below the region index never influence routing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ARADDR[REGION_LSB-1:0], AWADDR[REGION_LSB-1:0]};

    // Any region index that is not a real slave falls through to the default slave.
    function automatic logic [SEL_W-1:0] decode(input logic [REGION_W-1:0] region);
        logic [SEL_W-1:0] sel;
        sel = SEL_DEF;
        for (int k = 0; k < NUM_S; k++) begin
            if (region == REGION_W'(k)) begin
                sel = SEL_W'(k);
            end
        end
        return sel;
    endfunction

    assign ar_sel = decode(ARADDR[ADDR_W-1:REGION_LSB]);
    assign aw_sel = decode(AWADDR[ADDR_W-1:REGION_LSB]);

    // Read-side output steering: address ready while idle, slave R passthrough
    // or locally generated DECERR beats while a burst is active.
    always_comb begin
        ARREADY  = 1'b0;
        RID      = '0;
        RDATA    = '0;
        RRESP    = 2'b00;
        RLAST    = 1'b0;
        RVALID   = 1'b0;
        RREADY_S = '0;
        case (r_state)
            R_IDLE: begin
                if (ar_sel == SEL_DEF) begin
                    ARREADY = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_S; k++) begin
                        if (ar_sel == SEL_W'(k)) begin
                            ARREADY = ARREADY_S[k];
                        end
                    end
                end
                if (ARESET) begin
                    ARREADY = 1'b0;
                end
            end
            R_DATA: begin
                for (int k = 0; k < NUM_S; k++) begin
                    if (r_sel == SEL_W'(k)) begin
                        RID         = RID_S[k*ID_W +: ID_W];
                        RDATA       = RDATA_S[k*DATA_W +: DATA_W];
                        RRESP       = RRESP_S[k*2 +: 2];
                        RLAST       = RLAST_S[k];
                        RVALID      = RVALID_S[k];
                        RREADY_S[k] = RREADY;
                    end
                end
            end
            R_DERR: begin
                RVALID = 1'b1;
                RID    = r_id;
                RDATA  = '0;
                RRESP  = RESP_DECERR;
                RLAST  = (r_cnt == r_len);
            end
            default: begin
            end
        endcase
    end

    // Read FSM: latch the decoded target on AR accept, then wait for the
    // slave's RLAST or count out len+1 DECERR beats for the default slave.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            r_sel   <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ARVALID && ARREADY) begin
                        r_sel   <= ar_sel;
                        r_id    <= ARID;
                        r_len   <= ARLEN;
                        r_cnt   <= '0;
                        r_state <= (ar_sel == SEL_DEF) ? R_DERR : R_DATA;
                    end
                end
                R_DATA: begin
                    if (RVALID && RREADY && RLAST) begin
                        r_state <= R_IDLE;
                    end
                end
                R_DERR: begin
                    if (RREADY) begin
                        if (r_cnt == r_len) begin
                            r_cnt   <= '0;
                            r_state <= R_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

    // Write-side output steering: address ready while idle, data ready from
    // the selected slave, then B passthrough or a local DECERR response.
    always_comb begin
        AWREADY  = 1'b0;
        WREADY   = 1'b0;
        BID      = '0;
        BRESP    = 2'b00;
        BVALID   = 1'b0;
        BREADY_S = '0;
        case (w_state)
            W_IDLE: begin
                if (aw_sel == SEL_DEF) begin
                    AWREADY = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_S; k++) begin
                        if (aw_sel == SEL_W'(k)) begin
                            AWREADY = AWREADY_S[k];
                        end
                    end
                end
                if (ARESET) begin
                    AWREADY = 1'b0;
                end
            end
            W_DATA: begin
                if (w_sel == SEL_DEF) begin
                    WREADY = 1'b1;
                end else begin
                    for (int k = 0; k < NUM_S; k++) begin
                        if (w_sel == SEL_W'(k)) begin
                            WREADY = WREADY_S[k];
                        end
                    end
                end
            end
            W_RESP: begin
                if (w_sel == SEL_DEF) begin
                    BVALID = 1'b1;
                    BID    = w_id;
                    BRESP  = RESP_DECERR;
                end else begin
                    for (int k = 0; k < NUM_S; k++) begin
                        if (w_sel == SEL_W'(k)) begin
                            BID         = BID_S[k*ID_W +: ID_W];
                            BRESP       = BRESP_S[k*2 +: 2];
                            BVALID      = BVALID_S[k];
                            BREADY_S[k] = BREADY;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Write FSM: address accept, data beats until WLAST, then one B handshake.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state <= W_IDLE;
            w_sel   <= '0;
            w_id    <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        w_sel   <= aw_sel;
                        w_id    <= AWID;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (WVALID && WREADY && WLAST) begin
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (BVALID && BREADY) begin
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_resp_router.sv
// tb_axi_resp_router: randomized bench with behavioural slave models; expected
// R and B beats are queued when issued and checked by an independent monitor.
`timescale 1ns/1ps
module tb_axi_resp_router;

    localparam int NS  = 2;
    localparam int DEF = NS;

    typedef struct {
        logic [7:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_beat_t;

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } b_beat_t;

    logic          ACLK;
    logic          ARESET;
    logic          ARVALID;
    logic [31:0]   ARADDR;
    logic [7:0]    ARID;
    logic [3:0]    ARLEN;
    logic          ARREADY;
    logic [7:0]    RID;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;
    logic          AWVALID;
    logic [31:0]   AWADDR;
    logic [7:0]    AWID;
    logic          AWREADY;
    logic          WVALID;
    logic          WLAST;
    logic          WREADY;
    logic [7:0]    BID;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [NS-1:0]    ARREADY_S;
    logic [NS-1:0]    AWREADY_S;
    logic [NS-1:0]    WREADY_S;
    logic [NS*8-1:0]  RID_S;
    logic [NS*32-1:0] RDATA_S;
    logic [NS*2-1:0]  RRESP_S;
    logic [NS-1:0]    RLAST_S;
    logic [NS-1:0]    RVALID_S;
    logic [NS*8-1:0]  BID_S;
    logic [NS*2-1:0]  BRESP_S;
    logic [NS-1:0]    BVALID_S;
    logic [NS-1:0]    RREADY_S;
    logic [NS-1:0]    BREADY_S;

    r_beat_t r_exp[$];
    b_beat_t b_exp[$];
    r_beat_t mon_r;
    b_beat_t mon_b;

    int checks = 0;
    int errors = 0;

    logic [61:0] all_outs;
    assign all_outs = {ARREADY, RID, RDATA, RRESP, RLAST, RVALID, AWREADY, WREADY,
                       BID, BRESP, BVALID, RREADY_S, BREADY_S};

    axi_resp_router #(
        .NUM_S(NS), .ID_W(8), .DATA_W(32), .ADDR_W(32), .REGION_LSB(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .ARVALID(ARVALID), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWVALID(AWVALID), .AWADDR(AWADDR), .AWID(AWID), .AWREADY(AWREADY),
        .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARREADY_S(ARREADY_S), .AWREADY_S(AWREADY_S), .WREADY_S(WREADY_S),
        .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S), .RVALID_S(RVALID_S),
        .BID_S(BID_S), .BRESP_S(BRESP_S), .BVALID_S(BVALID_S),
        .RREADY_S(RREADY_S), .BREADY_S(BREADY_S)
    );

    // 100 MHz clock
    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=time limit reached required=normal completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Address map of the reference: region index below NS is that slave, else default
    function automatic int dec(input logic [31:0] a);
        int r;
        r = int'(a[31:16]);
        return (r < NS) ? r : DEF;
    endfunction

    function automatic logic pick(input logic [31:0] pat, input int patlen, input int cyc);
        if (patlen > 0) return (cyc < patlen) ? pat[cyc] : 1'b1;
        return 1'($urandom);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        logic [15:0] region;
        r = $urandom_range(4, 0);
        region = (r == 4) ? 16'hABCD : 16'(r);
        return {region, 16'($urandom)};
    endfunction

    // Unselected slaves always shout: valid high with garbage payload
    task automatic stray_r(input int k);
        for (int j = 0; j < NS; j++) begin
            if (j != k) begin
                RVALID_S[j]         = 1'b1;
                RLAST_S[j]          = 1'($urandom);
                RID_S[j*8 +: 8]     = 8'($urandom);
                RDATA_S[j*32 +: 32] = $urandom;
                RRESP_S[j*2 +: 2]   = 2'($urandom);
            end
        end
    endtask

    task automatic stray_b(input int k);
        for (int j = 0; j < NS; j++) begin
            if (j != k) begin
                BVALID_S[j]       = 1'b1;
                BID_S[j*8 +: 8]   = 8'($urandom);
                BRESP_S[j*2 +: 2] = 2'($urandom);
            end
        end
    endtask

    // Scoreboard monitor: compare whenever a response is presented, pop on handshake
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (RVALID) begin
                if (r_exp.size() == 0) begin
                    checkOutput("r_stray_valid", 64'(RVALID), 64'd0);
                end else begin
                    mon_r = r_exp[0];
                    checkOutput("r_id", 64'(RID), 64'(mon_r.id));
                    checkOutput("r_data", 64'(RDATA), 64'(mon_r.data));
                    checkOutput("r_resp", 64'(RRESP), 64'(mon_r.resp));
                    checkOutput("r_last", 64'(RLAST), 64'(mon_r.last));
                    if (RREADY) void'(r_exp.pop_front());
                end
            end
            if (BVALID) begin
                if (b_exp.size() == 0) begin
                    checkOutput("b_stray_valid", 64'(BVALID), 64'd0);
                end else begin
                    mon_b = b_exp[0];
                    checkOutput("b_id", 64'(BID), 64'(mon_b.id));
                    checkOutput("b_resp", 64'(BRESP), 64'(mon_b.resp));
                    if (BREADY) void'(b_exp.pop_front());
                end
            end
        end
    end

    task automatic ar_phase(input logic [31:0] addr, input logic [7:0] id, input logic [3:0] len, input int k);
        int t;
        logic done;
        logic exp_rdy;
        r_beat_t e;
        t = 0;
        done = 1'b0;
        ARVALID = 1'b1;
        ARADDR  = addr;
        ARID    = id;
        ARLEN   = len;
        while (!done && t < 300) begin
            ARREADY_S = 2'($urandom);
            stray_r(-1);
            @(negedge ACLK);
            if (k == DEF) exp_rdy = 1'b1;
            else          exp_rdy = ARREADY_S[k];
            checkOutput("arready", 64'(ARREADY), 64'(exp_rdy));
            done = ARREADY;
            if (done && k == DEF) begin
                for (int b = 0; b <= int'(len); b++) begin
                    e.id = id; e.data = 32'd0; e.resp = 2'b11; e.last = (b == int'(len));
                    r_exp.push_back(e);
                end
            end
            @(posedge ACLK); #1;
            t++;
        end
        if (!done) checkOutput("ar_accept", 64'(done), 64'd1);
        ARVALID   = 1'b0;
        ARADDR    = $urandom;
        ARREADY_S = 2'($urandom);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] id, input logic [3:0] len,
                           input logic [31:0] pat, input int patlen);
        int k;
        int cyc;
        logic hs;
        logic [7:0] sid;
        logic [NS-1:0] exp_rs;
        r_beat_t e;
        k = dec(addr);
        ar_phase(addr, id, len, k);
        cyc = 0;
        if (k == DEF) begin
            while (r_exp.size() > 0 && cyc < 300) begin
                RREADY = pick(pat, patlen, cyc);
                stray_r(-1);
                @(negedge ACLK);
                checkOutput("rready_s_def", 64'(RREADY_S), 64'd0);
                checkOutput("arready_busy", 64'(ARREADY), 64'd0);
                @(posedge ACLK); #1;
                cyc++;
            end
        end else begin
            sid = 8'($urandom);
            for (int beat = 0; beat <= int'(len) && cyc < 300; beat++) begin
                if ($urandom_range(3, 0) == 0) begin
                    RVALID_S[k] = 1'b0;
                    RREADY = pick(pat, patlen, cyc);
                    stray_r(k);
                    @(negedge ACLK);
                    exp_rs = '0; exp_rs[k] = RREADY;
                    checkOutput("rready_s_gap", 64'(RREADY_S), 64'(exp_rs));
                    @(posedge ACLK); #1;
                    cyc++;
                end
                e.id = sid; e.data = $urandom; e.resp = 2'($urandom); e.last = (beat == int'(len));
                RVALID_S[k]         = 1'b1;
                RID_S[k*8 +: 8]     = e.id;
                RDATA_S[k*32 +: 32] = e.data;
                RRESP_S[k*2 +: 2]   = e.resp;
                RLAST_S[k]          = e.last;
                r_exp.push_back(e);
                hs = 1'b0;
                while (!hs && cyc < 300) begin
                    RREADY = pick(pat, patlen, cyc);
                    stray_r(k);
                    @(negedge ACLK);
                    exp_rs = '0; exp_rs[k] = RREADY;
                    checkOutput("rready_s", 64'(RREADY_S), 64'(exp_rs));
                    checkOutput("arready_busy", 64'(ARREADY), 64'd0);
                    hs = RREADY;
                    @(posedge ACLK); #1;
                    cyc++;
                end
                RVALID_S[k] = 1'b0;
            end
        end
        checkOutput("r_burst_done", 64'(r_exp.size()), 64'd0);
        RREADY = 1'b0;
        stray_r(-1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] id, input int nbeats,
                            input logic [1:0] bresp, input logic fix_resp);
        int k;
        int cyc;
        int b;
        logic done;
        logic hs;
        logic exp_rdy;
        logic [NS-1:0] exp_bs;
        b_beat_t e;
        k = dec(addr);
        AWVALID = 1'b1;
        AWADDR  = addr;
        AWID    = id;
        WVALID  = 1'b1;
        WLAST   = 1'($urandom);
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < 300) begin
            AWREADY_S = 2'($urandom);
            WREADY_S  = 2'($urandom);
            stray_b(-1);
            @(negedge ACLK);
            if (k == DEF) exp_rdy = 1'b1;
            else          exp_rdy = AWREADY_S[k];
            checkOutput("awready", 64'(AWREADY), 64'(exp_rdy));
            checkOutput("wready_idle", 64'(WREADY), 64'd0);
            done = AWREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        if (!done) checkOutput("aw_accept", 64'(done), 64'd1);
        AWVALID = 1'b0;
        AWADDR  = $urandom;
        b = 0;
        cyc = 0;
        while (b < nbeats && cyc < 300) begin
            WVALID   = ($urandom_range(3, 0) != 0);
            WLAST    = (b == nbeats - 1);
            WREADY_S = 2'($urandom);
            stray_b(k);
            @(negedge ACLK);
            if (k == DEF) exp_rdy = 1'b1;
            else          exp_rdy = WREADY_S[k];
            checkOutput("wready", 64'(WREADY), 64'(exp_rdy));
            checkOutput("awready_busy", 64'(AWREADY), 64'd0);
            if (WVALID && WREADY) b++;
            @(posedge ACLK); #1;
            cyc++;
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        if (k == DEF) begin
            e.id = id; e.resp = 2'b11;
            b_exp.push_back(e);
        end else begin
            for (int g = $urandom_range(2, 0); g > 0; g--) begin
                BVALID_S[k] = 1'b0;
                BREADY = 1'($urandom);
                stray_b(k);
                @(negedge ACLK);
                exp_bs = '0; exp_bs[k] = BREADY;
                checkOutput("bready_s_gap", 64'(BREADY_S), 64'(exp_bs));
                @(posedge ACLK); #1;
            end
            e.id = 8'($urandom);
            e.resp = fix_resp ? bresp : 2'($urandom);
            BVALID_S[k]       = 1'b1;
            BID_S[k*8 +: 8]   = e.id;
            BRESP_S[k*2 +: 2] = e.resp;
            b_exp.push_back(e);
        end
        hs = 1'b0;
        cyc = 0;
        while (!hs && cyc < 300) begin
            BREADY = 1'($urandom);
            stray_b(k);
            @(negedge ACLK);
            exp_bs = '0;
            if (k != DEF) exp_bs[k] = BREADY;
            checkOutput("bready_s", 64'(BREADY_S), 64'(exp_bs));
            hs = BREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        if (k != DEF) BVALID_S[k] = 1'b0;
        BREADY = 1'b0;
        checkOutput("b_done", 64'(b_exp.size()), 64'd0);
        stray_b(-1);
    endtask

    // Randomized mix of reads, writes and overlapping read/write pairs
    task automatic applyStimulus(input int count);
        logic [31:0] raddr;
        logic [31:0] waddr;
        int op;
        for (int i = 0; i < count; i++) begin
            op    = $urandom_range(2, 0);
            raddr = rand_addr();
            waddr = rand_addr();
            case (op)
                0: do_read(raddr, 8'($urandom), 4'($urandom), 32'd0, 0);
                1: do_write(waddr, 8'($urandom), $urandom_range(4, 1), 2'b00, 1'b0);
                default: begin
                    fork
                        do_read(raddr, 8'($urandom), 4'($urandom), 32'd0, 0);
                        do_write(waddr, 8'($urandom), $urandom_range(4, 1), 2'b00, 1'b0);
                    join
                end
            endcase
        end
    endtask

    initial begin
        ARESET = 1'b1;
        ARVALID = 1'b0; ARADDR = 32'h00FF_0000; ARID = '0; ARLEN = '0;
        AWVALID = 1'b0; AWADDR = 32'h00FF_0000; AWID = '0;
        WVALID = 1'b0; WLAST = 1'b0;
        RREADY = 1'b1; BREADY = 1'b1;
        ARREADY_S = '1; AWREADY_S = '1; WREADY_S = '1;
        RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = '0; RVALID_S = '0;
        BID_S = '0; BRESP_S = '0; BVALID_S = '0;
        stray_r(-1);
        stray_b(-1);
        repeat (2) @(posedge ACLK);
        #1;
        checkOutput("reset_outputs", 64'(all_outs), 64'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        RREADY = 1'b0;
        BREADY = 1'b0;

        do_read(32'h0001_0040, 8'h55, 4'd3, 32'hFFFF_FFFF, 32);
        do_read(32'h0005_0000, 8'h3A, 4'd2, 32'h0000_000D, 4);
        do_write(32'h0000_0010, 8'h07, 2, 2'b00, 1'b1);
        do_write(32'h00FF_0000, 8'h11, 4, 2'b00, 1'b0);
        fork
            do_read(32'h0000_0300, 8'h21, 4'd5, 32'hFFFF_FFFF, 32);
            do_write(32'h0001_0400, 8'h42, 3, 2'b00, 1'b1);
        join

        ar_phase(32'h0007_0000, 8'h5C, 4'd3, DEF);
        RREADY = 1'b1;
        @(posedge ACLK); #2;
        ARESET = 1'b1;
        ARADDR = 32'h00FF_0000;
        AWADDR = 32'h00FF_0000;
        BREADY = 1'b1;
        #1;
        checkOutput("reset_midburst", 64'(all_outs), 64'd0);
        r_exp.delete();
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        RREADY = 1'b0;
        BREADY = 1'b0;
        do_read(32'h0000_2000, 8'h01, 4'd1, 32'd0, 0);

        applyStimulus(40);

        repeat (3) @(posedge ACLK);
        #1;
        checkOutput("r_pending_end", 64'(r_exp.size()), 64'd0);
        checkOutput("b_pending_end", 64'(b_exp.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
